// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that packs bytes into 32-bit words and writes instruction memory
module imem_loader #(
  parameter int AW         = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic [31:0]   checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  byte_cnt;
  logic [AW:0] word_cnt;
  logic [23:0] asm_q;     // first three bytes of the word being assembled
  logic [23:0] asm_next;
  logic [31:0] word_next;

  // Byte packing: big-endian shifts left (first byte ends up in [31:24]),
  // little-endian shifts right (first byte ends up in [7:0]).
  always_comb begin
    asm_next  = '0;
    word_next = '0;
    if (BIG_ENDIAN) begin
      asm_next  = {asm_q[15:0], in_data};
      word_next = {asm_q, in_data};
    end else begin
      asm_next  = {in_data, asm_q[23:8]};
      word_next = {in_data, asm_q};
    end
  end

  // Load sequencer: every output is a register so in_ready never depends on in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      asm_q    <= '0;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= '0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            checksum <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            if (len != '0) begin
              im_addr  <= base_addr;
              word_cnt <= len;
              in_ready <= 1'b1;
              state    <= RECV;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RECV: begin
          if (in_valid && in_ready) begin
            asm_q    <= asm_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_wdata <= word_next;
              im_we    <= 1'b1;
              in_ready <= 1'b0;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          checksum <= checksum ^ im_wdata;
          word_cnt <= word_cnt - (AW+1)'(1);
          byte_cnt <= '0;
          if (word_cnt == (AW+1)'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            im_addr  <= im_addr + AW'(1);
            in_ready <= 1'b1;
            state    <= RECV;
          end
        end
        DONE: begin
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader, big- and little-endian instances side by side
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        ready_be, we_be, hold_be, busy_be, done_be;
  logic [9:0]  addr_be;
  logic [31:0] wdata_be, cs_be;
  logic        ready_le, we_le, hold_le, busy_le, done_le;
  logic [9:0]  addr_le;
  logic [31:0] wdata_le, cs_le;

  always #5 clk = ~clk;

  imem_loader #(.AW(10), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ready_be), .im_we(we_be),
    .im_addr(addr_be), .im_wdata(wdata_be), .cpu_hold(hold_be), .busy(busy_be),
    .done(done_be), .checksum(cs_be)
  );

  imem_loader #(.AW(10), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ready_le), .im_we(we_le),
    .im_addr(addr_le), .im_wdata(wdata_le), .cpu_hold(hold_le), .busy(busy_le),
    .done(done_le), .checksum(cs_le)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [63:0] q_be[$];
  logic [63:0] q_le[$];
  logic [31:0] wbuf[$];
  logic [31:0] exp_cs_be, exp_cs_le;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always @(posedge clk) cyc++;

  // Write monitor: each im_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    logic [63:0] e;
    if (we_be) begin
      if (q_be.size() == 0) check("be_unexpected_we", {54'd0, addr_be}, 64'hffff_ffff_ffff_ffff);
      else begin
        e = q_be.pop_front();
        check("be_write", {22'd0, addr_be, wdata_be}, e);
      end
      last_we_cyc = cyc;
    end
    if (we_le) begin
      if (q_le.size() == 0) check("le_unexpected_we", {54'd0, addr_le}, 64'hffff_ffff_ffff_ffff);
      else begin
        e = q_le.pop_front();
        check("le_write", {22'd0, addr_le, wdata_le}, e);
      end
    end
    if (done_be) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Present one byte after gap idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_wait, input int exp_wait);
    int waits = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!ready_be && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) check("ready_timeout", 64'(waits), 64'd0);
    @(negedge clk);
    if (chk_wait) check("ready_wait", 64'(waits), 64'(exp_wait));
  endtask

  task automatic run_load(input logic [9:0] base, input int gap_max, input bit stray);
    int d0;
    int n = wbuf.size();
    logic [9:0]  a;
    logic [31:0] w;
    @(negedge clk);
    start = 1'b1; base_addr = base; len = 11'(n);
    @(negedge clk);
    start = 1'b0;
    base_addr = 10'h2aa;
    len = 11'd3;
    check("busy_on", {62'd0, busy_be, hold_be}, 64'd3);
    d0 = done_cnt;
    exp_cs_be = '0;
    exp_cs_le = '0;
    for (int k = 0; k < n; k++) begin
      w = wbuf[k];
      a = base + 10'(k);
      q_be.push_back({22'd0, a, w});
      q_le.push_back({22'd0, a, rev(w)});
      exp_cs_be ^= w;
      exp_cs_le ^= rev(w);
      for (int i = 0; i < 4; i++) begin
        if (stray && k == 1 && i == 2) begin
          in_valid = 1'b0;
          start = 1'b1; base_addr = 10'h3ff; len = 11'd1;
          @(negedge clk);
          start = 1'b0;
        end
        send_byte(w[31-8*i -: 8], (gap_max > 0) ? $urandom_range(0, gap_max) : 0,
                  gap_max == 0 && !stray, (k > 0 && i == 0) ? 1 : 0);
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 20 && done_cnt == d0; t++) begin
      @(negedge clk);
      #1;
    end
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("done_after_we", 64'(done_cyc - last_we_cyc), 64'd1);
    check("queue_be_empty", 64'(q_be.size()), 64'd0);
    check("queue_le_empty", 64'(q_le.size()), 64'd0);
    check("checksum_be", {32'd0, cs_be}, {32'd0, exp_cs_be});
    check("checksum_le", {32'd0, cs_le}, {32'd0, exp_cs_le});
    @(negedge clk);
    #1;
    check("idle_after_done", {61'd0, busy_be, hold_be, done_be}, 64'd0);
    q_be.delete();
    q_le.delete();
  endtask

  initial begin
    int d0;
    logic [31:0] three[$];
    rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", {59'd0, ready_be, we_be, busy_be, hold_be, done_be}, 64'd0);
    check("reset_data", {22'd0, addr_be, wdata_be}, 64'd0);
    check("reset_checksum", {32'd0, cs_be}, 64'd0);
    rst = 1'b1;

    // Abort a load after two bytes with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd5; len = 11'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'haa, 0, 1'b0, 0);
    send_byte(8'hbb, 0, 1'b0, 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midreset_ctrl", {60'd0, ready_be, we_be, busy_be, hold_be}, 64'd0);
    check("midreset_addr", {54'd0, addr_be}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wbuf = '{32'h11223344};
    run_load(10'd5, 0, 1'b0);

    // Single word, then the little-endian byte order case.
    wbuf = '{32'h20080005};
    run_load(10'h010, 0, 1'b0);
    wbuf = '{32'h05000820};
    run_load(10'h011, 0, 1'b0);

    // Three words back-to-back; in_ready wait pattern checked per byte.
    three = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef};
    wbuf = three;
    run_load(10'h100, 0, 1'b0);

    // Address wrap at the top of memory.
    wbuf = '{32'hcafef00d, 32'h0badc0de};
    run_load(10'd1023, 0, 1'b0);

    // len=0: done pulse, no write, checksum cleared.
    @(negedge clk);
    start = 1'b1; base_addr = 10'd3; len = 11'd0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 4 && done_cnt == d0; t++) begin
      @(negedge clk);
      #1;
    end
    check("len0_done", 64'(done_cnt - d0), 64'd1);
    check("len0_checksum", {cs_be, cs_le}, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("len0_idle", {62'd0, busy_be, hold_be}, 64'd0);

    // Random input gaps and a stray start: same words, same results.
    wbuf = three;
    run_load(10'h100, 7, 1'b1);
    wbuf.delete();
    for (int k = 0; k < 5; k++) wbuf.push_back($urandom());
    run_load(10'h040, 7, 1'b0);

    // Full 1024-word load.
    wbuf.delete();
    for (int k = 0; k < 1024; k++) wbuf.push_back($urandom());
    run_load(10'h200, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the instruction memory that the CPU fetches from.
- Accepts bytes over a valid/ready handshake and packs them into 32-bit words.
- Writes each word into the 4 KB instruction memory at consecutive word addresses (the same word indexing as PC[11:2]).
- Holds the CPU via cpu_hold while loading, so a program can be loaded at runtime instead of preloaded at simulation start.

Parameters:
- AW, 10, word-address width of instruction memory (1024 words).
- BIG_ENDIAN, 1, 1: first byte received is instr[31:24]; 0: first byte is instr[7:0].

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- base_addr  input  AW  first word address to write.
- len  input  AW+1  number of words to load, 0..1024.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  AW  instruction-memory word address.
- im_wdata  output  32  instruction-memory write data.
- cpu_hold  output  1  high while a load is in progress; CPU PC held in reset.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when load completes.
- checksum  output  32  XOR of all words written in the current or most recent load.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. in_ready, im_we, cpu_hold, busy, done = 0. im_addr=0, im_wdata=0, checksum=0. Byte counter and word counter cleared.
- All outputs are registered; no combinational path from in_valid to in_ready.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 and len!=0: latch base_addr into im_addr, latch len into the word counter, clear checksum, go RECV. busy=cpu_hold=1 from the next cycle.
  - start=1 and len=0: go DONE directly. checksum cleared; no write issued.
- RECV:
  - in_ready=1.
  - Byte accepted on a rising edge when in_valid && in_ready; shifted into the assembly register per BIG_ENDIAN; byte counter increments 0..3.
  - When byte 3 is accepted: im_wdata is loaded with the assembled word and the state goes to WRITE.
  - in_valid low: state holds indefinitely, no timeout.
- WRITE (exactly one cycle):
  - im_we=1, in_ready=0; im_addr and im_wdata stable.
  - At the end of the cycle: checksum ^= im_wdata, word counter decrements, byte counter clears.
  - Word counter reaches 0: go DONE. Otherwise im_addr increments and state returns to RECV.
- Latency: 4th byte accepted at edge N -> im_we high during cycle N+1 -> next byte can be accepted at edge N+2.
- Sustained throughput: 4 bytes per 5 cycles.
- im_addr wraps modulo 2^AW: base_addr=1023 with len=2 writes 1023, then 0.
- DONE (one cycle): done=1; busy and cpu_hold drop to 0 on the next edge together with the return to IDLE. checksum holds its value until the next accepted start.
- start while not in IDLE: ignored, with no effect on counters or address.
- in_data while in_ready=0: ignored; it is not consumed.
- Reset asserted mid-load: all state aborts immediately. Words already written stay in memory; partial bytes are discarded; cpu_hold drops.
- Width rules: checksum is a 32-bit XOR with no carry. len is AW+1 bits so a full 1024-word load is expressible.

Test Plan:
- Reset: drive rst=0 mid-RECV after 2 bytes -> in_ready, im_we, busy, cpu_hold = 0 immediately. After release, start with len=1 and bytes 11,22,33,44 -> single write im_addr=base, im_wdata=0x11223344.
- Single word, BIG_ENDIAN=1, base_addr=0x010, len=1, bytes 0x20,0x08,0x00,0x05 -> one im_we pulse at addr 0x010 with data 0x20080005. done pulse follows one cycle later. checksum=0x20080005.
- Three words back-to-back, in_valid held high -> in_ready pattern 1,1,1,1,0 repeats. Writes land at base, base+1, base+2. checksum = XOR of the three words. No byte dropped or duplicated.
- Wrap and len=0: base_addr=1023, len=2 -> writes at 1023 then 0. start with len=0 -> done pulse two cycles after start, no im_we.
- Backpressure and stray start: gaps in in_valid of random length 0–7 cycles -> identical written data to the gap-free run. start pulsed during RECV -> ignored, same final checksum.
- BIG_ENDIAN=0, bytes 0x05,0x00,0x08,0x20 -> im_wdata=0x20080005.
